// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module : cpu_pkg
//  Brief  : Shared constants, fetch-FSM state encoding and opcode helper used
//           by the IF/ID stage and its sub-modules.
//  Rev    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam logic [15:0] C_RESET_PC    = 16'h0000;
    localparam logic [15:0] C_NOP_INSTR   = 16'b00001_00000000000;
    localparam logic [4:0]  C_HALT_OPCODE = 5'b00000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,   // request outstanding at pc
        ST_DROP  = 2'd1,   // cancelled request still in flight
        ST_HOLD  = 2'd2,   // response parked in skid buffer during a stall
        ST_HALT  = 2'd3    // HALT handed to decode, fetch stopped
    } fetch_state_t;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[15:11] == C_HALT_OPCODE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dff1.sv
`default_nettype none
// ============================================================================
//  Module : dff1
//  Brief  : 1-bit enabled flop with synchronous active-high reset.
//  Ports  : clk, rst, en, d -> q
//  Rev    : 1.0  initial release
// ============================================================================
module dff1 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk) begin
        if (rst)     q <= RST_VAL;
        else if (en) q <= d;
    end
endmodule
`default_nettype wire

// File: rtl/dff16.sv
`default_nettype none
// ============================================================================
//  Module : dff16
//  Brief  : 16-bit enabled register with synchronous active-high reset.
//  Ports  : clk, rst, en, d[15:0] -> q[15:0]
//  Rev    : 1.0  initial release
// ============================================================================
module dff16 #(
    parameter logic [15:0] RST_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] d,
    output logic [15:0] q
);
    always_ff @(posedge clk) begin
        if (rst)     q <= RST_VAL;
        else if (en) q <= d;
    end
endmodule
`default_nettype wire

// File: rtl/ifid_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module : ifid_skid_buf
//  Brief  : One-entry skid buffer {instr, pc+2, valid} that parks a fetch
//           response arriving while decode is stalled.
//  Ports  : clk, rst, load, clear, instr_in, pc_plus2_in
//           -> instr_out, pc_plus2_out, valid_out
//  Rev    : 1.0  initial release
// ============================================================================
module ifid_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_plus2_in,
    output logic [15:0] instr_out,
    output logic [15:0] pc_plus2_out,
    output logic        valid_out
);
    logic        w_en;
    logic [15:0] w_instr_d;
    logic [15:0] w_pc2_d;

    // clear wins over load so a squashed entry can never survive
    assign w_en      = load | clear;
    assign w_instr_d = clear ? 16'h0000 : instr_in;
    assign w_pc2_d   = clear ? 16'h0000 : pc_plus2_in;

    dff16 u_instr (.clk(clk), .rst(rst), .en(w_en), .d(w_instr_d), .q(instr_out));
    dff16 u_pc2   (.clk(clk), .rst(rst), .en(w_en), .d(w_pc2_d),   .q(pc_plus2_out));
    dff1  u_valid (.clk(clk), .rst(rst), .en(w_en), .d(~clear),    .q(valid_out));
endmodule
`default_nettype wire

// File: rtl/ifid_stage.sv
`default_nettype none
// ============================================================================
//  Module : ifid_stage
//  Brief  : Instruction fetch + IF/ID pipeline register. Owns the PC, talks to
//           a variable-latency instruction memory, absorbs decode stalls with
//           a skid buffer, applies redirects and stops after HALT.
//  Ports  : clk, rst, stall_in, redirect_in, redirect_pc_in[15:0]
//           imem_rd_out, imem_addr_out[15:0], imem_data_in[15:0], imem_ready_in
//           instr_out[15:0], pc_plus2_out[15:0], valid_out, halted_out
//  Rev    : 1.0  initial release
// ============================================================================
module ifid_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = C_RESET_PC,
    parameter logic [15:0] NOP_INSTR = C_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect_in,
    input  logic [15:0] redirect_pc_in,
    output logic        imem_rd_out,
    output logic [15:0] imem_addr_out,
    input  logic [15:0] imem_data_in,
    input  logic        imem_ready_in,
    output logic [15:0] instr_out,
    output logic [15:0] pc_plus2_out,
    output logic        valid_out,
    output logic        halted_out
);
    fetch_state_t r_state, w_state_next;

    logic [15:0] r_pc, r_pend, w_pc_d, w_pend_d, w_pc_plus2;
    logic        w_pc_en, w_pend_en;
    logic        w_buf_load, w_buf_clear;
    logic [15:0] r_buf_instr, r_buf_pc2;
    logic        r_buf_valid;
    logic        w_ifid_load, w_ifid_bubble, w_ifid_valid_d;
    logic [15:0] w_ifid_instr_d, w_ifid_pc2_d, w_instr_reg_d;

    assign w_pc_plus2 = r_pc + 16'd2;   // wraps silently

    // memory-facing outputs depend only on state/pc (and reset)
    assign imem_rd_out   = ~rst & ((r_state == ST_FETCH) | (r_state == ST_DROP));
    assign imem_addr_out = r_pc;
    assign halted_out    = (r_state == ST_HALT);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_FETCH;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        w_pc_en        = 1'b0;
        w_pc_d         = r_pc;
        w_pend_en      = 1'b0;
        w_pend_d       = r_pend;
        w_buf_load     = 1'b0;
        w_buf_clear    = 1'b0;
        w_ifid_load    = 1'b0;
        w_ifid_bubble  = 1'b0;
        w_ifid_instr_d = imem_data_in;
        w_ifid_pc2_d   = w_pc_plus2;
        w_ifid_valid_d = 1'b1;
        unique case (r_state)
            ST_FETCH: begin
                if (imem_ready_in) begin
                    w_pc_en = 1'b1;
                    w_pc_d  = w_pc_plus2;
                    if (redirect_in) begin
                        w_pc_d        = redirect_pc_in;
                        w_ifid_bubble = 1'b1;
                    end else if (stall_in) begin
                        w_buf_load   = 1'b1;
                        w_state_next = ST_HOLD;
                    end else begin
                        w_ifid_load = 1'b1;
                        if (is_halt(imem_data_in)) w_state_next = ST_HALT;
                    end
                end else if (redirect_in) begin
                    w_pend_en     = 1'b1;
                    w_pend_d      = redirect_pc_in;
                    w_state_next  = ST_DROP;
                    w_ifid_bubble = 1'b1;
                end else begin
                    w_ifid_bubble = ~stall_in;
                end
            end
            ST_DROP: begin
                w_ifid_bubble = redirect_in | ~stall_in;
                if (redirect_in) begin
                    w_pend_en = 1'b1;
                    w_pend_d  = redirect_pc_in;
                end
                if (imem_ready_in) begin
                    // a redirect arriving with the response is the latest target
                    w_pc_en      = 1'b1;
                    w_pc_d       = redirect_in ? redirect_pc_in : r_pend;
                    w_state_next = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redirect_in) begin
                    w_buf_clear   = 1'b1;
                    w_pc_en       = 1'b1;
                    w_pc_d        = redirect_pc_in;
                    w_ifid_bubble = 1'b1;
                    w_state_next  = ST_FETCH;
                end else if (!stall_in) begin
                    w_ifid_load    = 1'b1;
                    w_ifid_instr_d = r_buf_instr;
                    w_ifid_pc2_d   = r_buf_pc2;
                    w_ifid_valid_d = r_buf_valid;
                    w_state_next   = is_halt(r_buf_instr) ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                w_ifid_bubble = redirect_in | ~stall_in;
                if (redirect_in) begin
                    w_pc_en      = 1'b1;
                    w_pc_d       = redirect_pc_in;
                    w_state_next = ST_FETCH;
                end
            end
            default: w_state_next = ST_FETCH;
        endcase
    end

    dff16 #(.RST_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .en(w_pc_en), .d(w_pc_d), .q(r_pc));
    dff16 u_pend (
        .clk(clk), .rst(rst), .en(w_pend_en), .d(w_pend_d), .q(r_pend));

    ifid_skid_buf u_skid (
        .clk(clk), .rst(rst), .load(w_buf_load), .clear(w_buf_clear),
        .instr_in(imem_data_in), .pc_plus2_in(w_pc_plus2),
        .instr_out(r_buf_instr), .pc_plus2_out(r_buf_pc2), .valid_out(r_buf_valid));

    // IF/ID register: a bubble rewrites instr/valid but keeps pc_plus2
    assign w_instr_reg_d = w_ifid_load ? w_ifid_instr_d : NOP_INSTR;

    dff16 #(.RST_VAL(NOP_INSTR)) u_ifid_instr (
        .clk(clk), .rst(rst), .en(w_ifid_load | w_ifid_bubble),
        .d(w_instr_reg_d), .q(instr_out));
    dff16 u_ifid_pc2 (
        .clk(clk), .rst(rst), .en(w_ifid_load), .d(w_ifid_pc2_d), .q(pc_plus2_out));
    dff1 u_ifid_valid (
        .clk(clk), .rst(rst), .en(w_ifid_load | w_ifid_bubble),
        .d(w_ifid_load & w_ifid_valid_d), .q(valid_out));
endmodule
`default_nettype wire
